// File: rtl/mesh_packetizer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mesh_packetizer_if
//  Description : Request, payload and flit-output handshake bundle for the
//                mesh local-port packetizer. The slave side is the packetizer
//                and the master side is the core/node environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mesh_packetizer_if #(
  parameter int FLIT_DATA_W = 8,
  parameter int FLIT_ID_W   = 2,
  parameter int ROW_ADDR_W  = 2,
  parameter int COL_ADDR_W  = 2,
  parameter int LEN_W       = 4,
  parameter int PKT_CNT_W   = 8
);
  // Packet request channel
  logic                           pkt_vld_i;
  logic                           pkt_rdy_o;
  logic [ROW_ADDR_W-1:0]          pkt_dst_row_i;
  logic [COL_ADDR_W-1:0]          pkt_dst_col_i;
  logic [LEN_W-1:0]               pkt_len_i;
  // Payload word channel
  logic [FLIT_DATA_W-1:0]         pl_data_i;
  logic                           pl_vld_i;
  logic                           pl_rdy_o;
  // Flit output channel towards the node local input
  logic [FLIT_ID_W+FLIT_DATA_W-1:0] out_flit_o;
  logic                           out_vld_o;
  logic                           out_rdy_i;
  // Status
  logic                           busy_o;
  logic [PKT_CNT_W-1:0]           pkt_cnt_o;

  modport slave (
    input  pkt_vld_i, pkt_dst_row_i, pkt_dst_col_i, pkt_len_i,
    input  pl_data_i, pl_vld_i, out_rdy_i,
    output pkt_rdy_o, pl_rdy_o, out_flit_o, out_vld_o, busy_o, pkt_cnt_o
  );

  modport master (
    output pkt_vld_i, pkt_dst_row_i, pkt_dst_col_i, pkt_len_i,
    output pl_data_i, pl_vld_i, out_rdy_i,
    input  pkt_rdy_o, pl_rdy_o, out_flit_o, out_vld_o, busy_o, pkt_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/mesh_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : mesh_packetizer
//  Description : Local-port network interface of a mesh wormhole node. Turns
//                a packet request plus a payload word stream into a
//                head/body/tail flit stream through a single output register,
//                running back-to-back packets without bubbles.
//  Revision    : 1.0 - initial release
// ============================================================================
module mesh_packetizer #(
  parameter int FLIT_DATA_W = 8,
  parameter int FLIT_ID_W   = 2,
  parameter int HOP_CNT_W   = 4,
  parameter int ROW_ADDR_W  = 2,
  parameter int COL_ADDR_W  = 2,
  parameter int LEN_W       = 4,
  parameter int PKT_CNT_W   = 8
) (
  input wire              clk_i,
  input wire              rst_ni,
  mesh_packetizer_if.slave bus
);

  localparam int c_flit_w = FLIT_ID_W + FLIT_DATA_W;

  // FSM encoding
  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_payload = 2'd1;
  localparam logic [1:0] c_st_ztail   = 2'd2;

  // Flit type encodings; upper bits stay zero for wider ID fields
  localparam logic [FLIT_ID_W-1:0] c_id_head = FLIT_ID_W'(2'b10);
  localparam logic [FLIT_ID_W-1:0] c_id_body = FLIT_ID_W'(2'b00);
  localparam logic [FLIT_ID_W-1:0] c_id_tail = FLIT_ID_W'(2'b11);

  localparam logic [LEN_W-1:0] c_rem_one = LEN_W'(1);

  logic [1:0]             r_state;
  logic [LEN_W-1:0]       r_rem;
  logic [c_flit_w-1:0]    r_out_flit;
  logic                   r_out_vld;
  logic [PKT_CNT_W-1:0]   r_pkt_cnt;

  logic                   w_load;
  logic                   w_pkt_fire;
  logic                   w_pl_fire;
  logic                   w_tail_xfer;
  logic [FLIT_DATA_W-1:0] w_head_data;

  // The output register may take a new flit when empty or draining this cycle
  assign w_load = !r_out_vld || bus.out_rdy_i;

  // Readies depend only on state and load, never on the upstream valids
  assign bus.pkt_rdy_o = (r_state == c_st_idle)    && w_load;
  assign bus.pl_rdy_o  = (r_state == c_st_payload) && w_load;

  assign w_pkt_fire  = bus.pkt_vld_i && bus.pkt_rdy_o;
  assign w_pl_fire   = bus.pl_vld_i  && bus.pl_rdy_o;
  assign w_tail_xfer = r_out_vld && bus.out_rdy_i &&
                       (r_out_flit[c_flit_w-1 -: FLIT_ID_W] == c_id_tail);

  assign bus.out_flit_o = r_out_flit;
  assign bus.out_vld_o  = r_out_vld;
  assign bus.busy_o     = (r_state != c_st_idle) || r_out_vld;
  assign bus.pkt_cnt_o  = r_pkt_cnt;

  // Head data: destination row/col in the MSBs, zero hop count in the LSBs
  always_comb begin
    w_head_data = '0;
    w_head_data[FLIT_DATA_W-1 -: ROW_ADDR_W]            = bus.pkt_dst_row_i;
    w_head_data[FLIT_DATA_W-ROW_ADDR_W-1 -: COL_ADDR_W] = bus.pkt_dst_col_i;
    w_head_data[HOP_CNT_W-1:0]                          = '0;
  end

  // FSM, remaining-payload counter and output register advance only on load
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= c_st_idle;
      r_rem      <= '0;
      r_out_flit <= '0;
      r_out_vld  <= 1'b0;
    end else if (w_load) begin
      case (r_state)
        c_st_idle: begin
          if (w_pkt_fire) begin
            r_out_flit <= {c_id_head, w_head_data};
            r_out_vld  <= 1'b1;
            r_rem      <= bus.pkt_len_i;
            r_state    <= (bus.pkt_len_i == '0) ? c_st_ztail : c_st_payload;
          end else begin
            r_out_vld  <= 1'b0;
          end
        end
        c_st_payload: begin
          if (w_pl_fire) begin
            // The last outstanding word closes the packet as the tail
            r_out_flit <= {((r_rem > c_rem_one) ? c_id_body : c_id_tail), bus.pl_data_i};
            r_out_vld  <= 1'b1;
            r_rem      <= r_rem - c_rem_one;
            if (r_rem <= c_rem_one) begin
              r_state  <= c_st_idle;
            end
          end else begin
            r_out_vld  <= 1'b0;
          end
        end
        c_st_ztail: begin
          // Zero-length packet: synthetic tail with no payload consumed
          r_out_flit <= {c_id_tail, {FLIT_DATA_W{1'b0}}};
          r_out_vld  <= 1'b1;
          r_state    <= c_st_idle;
        end
        default: begin
          r_state    <= c_st_idle;
          r_out_vld  <= 1'b0;
        end
      endcase
    end
  end

  // Count tail flits accepted by the node; wraps naturally
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pkt_cnt <= '0;
    end else if (w_tail_xfer) begin
      r_pkt_cnt <= r_pkt_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mesh_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mesh_packetizer
//  Description : Self-checking bench for mesh_packetizer: directed table of
//                packets, back-to-back, randomized traffic against a
//                queue-based packet model, mid-packet reset and counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mesh_packetizer;

  localparam int DW = 8;
  localparam int FW = 10;
  localparam logic [1:0] ID_HEAD = 2'b10;
  localparam logic [1:0] ID_BODY = 2'b00;
  localparam logic [1:0] ID_TAIL = 2'b11;
  localparam int CYC_BUDGET = 20000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mesh_packetizer_if #(
    .FLIT_DATA_W(8), .FLIT_ID_W(2), .ROW_ADDR_W(2), .COL_ADDR_W(2),
    .LEN_W(4), .PKT_CNT_W(8)
  ) pif ();

  mesh_packetizer #(
    .FLIT_DATA_W(8), .FLIT_ID_W(2), .HOP_CNT_W(4), .ROW_ADDR_W(2),
    .COL_ADDR_W(2), .LEN_W(4), .PKT_CNT_W(8)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (pif)
  );

  typedef struct packed {
    logic [1:0]    row;
    logic [1:0]    col;
    logic [3:0]    len;
    logic [7:0]    base;
    logic [FW-1:0] exp_head;
    logic [FW-1:0] exp_tail;
  } dir_t;

  int n_pass    = 0;
  int n_total   = 0;
  int model_cnt = 0;

  logic [FW-1:0] exp_q[$];
  logic [DW-1:0] pl_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got 0x%0h, expected none", name, act);
  endtask

  // Head flit straight from the layout: {HEAD, row, col, hop=0}
  function automatic logic [FW-1:0] head_of(input logic [1:0] row, input logic [1:0] col);
    return {ID_HEAD, row, col, 4'h0};
  endfunction

  // One packet with the node always ready and payload always available
  task automatic run_directed(input dir_t r);
    int nfl;
    logic [FW-1:0] exp;
    nfl = (r.len == 4'd0) ? 2 : int'(r.len) + 1;
    @(negedge clk);
    pif.pkt_vld_i     = 1'b1;
    pif.pkt_dst_row_i = r.row;
    pif.pkt_dst_col_i = r.col;
    pif.pkt_len_i     = r.len;
    pif.pl_vld_i      = 1'b0;
    pif.out_rdy_i     = 1'b1;
    #1 check("dir_pkt_rdy", 32'(pif.pkt_rdy_o), 32'd1);
    for (int c = 1; c <= nfl; c++) begin
      @(negedge clk);
      pif.pkt_vld_i = 1'b0;
      if (c == 1)        exp = r.exp_head;
      else if (c == nfl) exp = r.exp_tail;
      else               exp = {ID_BODY, 8'(int'(r.base) + c - 1)};
      check("dir_vld", 32'(pif.out_vld_o), 32'd1);
      check("dir_flit", 32'(pif.out_flit_o), 32'(exp));
      if (r.len == 4'd0) begin
        pif.pl_vld_i  = 1'b1;
        pif.pl_data_i = 8'hEE;
        #1 check("ztail_pl_rdy", 32'(pif.pl_rdy_o), 32'd0);
      end else if (c <= int'(r.len)) begin
        pif.pl_vld_i  = 1'b1;
        pif.pl_data_i = 8'(int'(r.base) + c);
        #1 check("dir_pl_rdy", 32'(pif.pl_rdy_o), 32'd1);
      end else begin
        pif.pl_vld_i  = 1'b0;
      end
    end
    @(negedge clk);
    pif.pl_vld_i = 1'b0;
    model_cnt++;
    check("dir_idle_vld", 32'(pif.out_vld_o), 32'd0);
    check("dir_busy", 32'(pif.busy_o), 32'd0);
    check("dir_cnt", 32'(pif.pkt_cnt_o), 32'(model_cnt[7:0]));
  endtask

  // Streamed traffic checked against the packet-level model queues
  task automatic run_stream(input int npkts, input int rdy_pct, input int plv_pct,
                            input int req_pct, input int fixed_len,
                            output int xfers, output int span);
    int            issued;
    int            cyc;
    int            first;
    int            last;
    bit            req_pending;
    bit            prev_stall;
    logic [FW-1:0] prev_flit;
    logic [FW-1:0] e;
    logic [1:0]    rr;
    logic [1:0]    rc;
    logic [3:0]    rl;
    logic [7:0]    w;
    issued = 0; cyc = 0; first = -1; last = -1; xfers = 0;
    req_pending = 1'b0; prev_stall = 1'b0; prev_flit = '0;
    rr = '0; rc = '0; rl = '0;
    while ((issued < npkts || req_pending || exp_q.size() != 0) && cyc < CYC_BUDGET) begin
      @(negedge clk);
      cyc++;
      if (prev_stall)
        check("stall_hold", 32'({pif.out_vld_o, pif.out_flit_o}), 32'({1'b1, prev_flit}));
      check("pkt_cnt", 32'(pif.pkt_cnt_o), 32'(model_cnt[7:0]));
      if (!req_pending && issued < npkts) begin
        rr = 2'($urandom);
        rc = 2'($urandom);
        rl = (fixed_len >= 0) ? 4'(fixed_len) : 4'($urandom_range(0, 15));
        req_pending = 1'b1;
        issued++;
      end
      pif.pkt_vld_i     = req_pending && ($urandom_range(0, 99) < req_pct);
      pif.pkt_dst_row_i = rr;
      pif.pkt_dst_col_i = rc;
      pif.pkt_len_i     = rl;
      pif.pl_vld_i      = (pl_q.size() != 0) && ($urandom_range(0, 99) < plv_pct);
      pif.pl_data_i     = (pl_q.size() != 0) ? pl_q[0] : 8'h00;
      pif.out_rdy_i     = ($urandom_range(0, 99) < rdy_pct);
      #1;
      if (pif.out_vld_o && !pif.out_rdy_i)
        check("stall_ready", 32'({pif.pkt_rdy_o, pif.pl_rdy_o}), 32'd0);
      if (pif.out_vld_o && pif.out_rdy_i) begin
        if (exp_q.size() == 0) begin
          fail_now("extra_flit", 32'(pif.out_flit_o));
        end else begin
          e = exp_q.pop_front();
          check("flit", 32'(pif.out_flit_o), 32'(e));
          if (e[FW-1 -: 2] == ID_TAIL) model_cnt++;
        end
        if (first < 0) first = cyc;
        last = cyc;
        xfers++;
      end
      prev_stall = pif.out_vld_o && !pif.out_rdy_i;
      prev_flit  = pif.out_flit_o;
      if (pif.pkt_vld_i && pif.pkt_rdy_o) begin
        exp_q.push_back(head_of(rr, rc));
        if (rl == 4'd0) begin
          exp_q.push_back({ID_TAIL, 8'h00});
        end else begin
          for (int i = 1; i <= int'(rl); i++) begin
            w = 8'($urandom);
            pl_q.push_back(w);
            exp_q.push_back({((i == int'(rl)) ? ID_TAIL : ID_BODY), w});
          end
        end
        req_pending = 1'b0;
      end
      if (pif.pl_vld_i && pif.pl_rdy_o) void'(pl_q.pop_front());
    end
    pif.pkt_vld_i = 1'b0;
    pif.pl_vld_i  = 1'b0;
    pif.out_rdy_i = 1'b1;
    if (cyc >= CYC_BUDGET) fail_now("stream_timeout", 32'(exp_q.size()));
    span = (first < 0) ? 0 : (last - first + 1);
  endtask

  dir_t tbl[4];
  int   xf;
  int   sp;

  initial begin
    tbl[0] = '{row: 2'd1, col: 2'd2, len: 4'd3,  base: 8'hA0, exp_head: 10'h260, exp_tail: 10'h3A3};
    tbl[1] = '{row: 2'd3, col: 2'd3, len: 4'd0,  base: 8'h00, exp_head: 10'h2F0, exp_tail: 10'h300};
    tbl[2] = '{row: 2'd0, col: 2'd0, len: 4'd1,  base: 8'h5A, exp_head: 10'h200, exp_tail: 10'h35B};
    tbl[3] = '{row: 2'd2, col: 2'd1, len: 4'd15, base: 8'hF0, exp_head: 10'h290, exp_tail: 10'h3FF};

    pif.pkt_vld_i     = 1'b0;
    pif.pkt_dst_row_i = '0;
    pif.pkt_dst_col_i = '0;
    pif.pkt_len_i     = '0;
    pif.pl_data_i     = '0;
    pif.pl_vld_i      = 1'b0;
    pif.out_rdy_i     = 1'b1;
    rst_n             = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_vld", 32'(pif.out_vld_o), 32'd0);
    check("rst_out_flit", 32'(pif.out_flit_o), 32'd0);
    check("rst_pkt_cnt", 32'(pif.pkt_cnt_o), 32'd0);
    check("rst_busy", 32'(pif.busy_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_pkt_rdy", 32'(pif.pkt_rdy_o), 32'd1);
    check("rst_pl_rdy", 32'(pif.pl_rdy_o), 32'd0);

    // Directed packet table
    for (int k = 0; k < 4; k++) run_directed(tbl[k]);

    // Two back-to-back N=2 packets: six flits with no gap
    run_stream(2, 100, 100, 100, 2, xf, sp);
    check("b2b_flits", 32'(xf), 32'd6);
    check("b2b_span", 32'(sp), 32'd6);
    @(negedge clk);
    check("b2b_cnt", 32'(pif.pkt_cnt_o), 32'(model_cnt[7:0]));

    // Randomized backpressure and payload gaps
    run_stream(200, 50, 70, 80, -1, xf, sp);
    @(negedge clk);
    check("rand_cnt", 32'(pif.pkt_cnt_o), 32'(model_cnt[7:0]));

    // Reset during a body flit of an N=5 packet
    pif.pkt_vld_i     = 1'b1;
    pif.pkt_dst_row_i = 2'd2;
    pif.pkt_dst_col_i = 2'd1;
    pif.pkt_len_i     = 4'd5;
    pif.pl_vld_i      = 1'b0;
    pif.out_rdy_i     = 1'b1;
    @(negedge clk);
    pif.pkt_vld_i = 1'b0;
    pif.pl_vld_i  = 1'b1;
    pif.pl_data_i = 8'h11;
    check("mid_head", 32'(pif.out_flit_o), 32'h290);
    @(negedge clk);
    check("mid_body", 32'(pif.out_flit_o), 32'({ID_BODY, 8'h11}));
    pif.pl_data_i = 8'h22;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pif.pl_vld_i = 1'b0;
    check("mid_rst_vld", 32'(pif.out_vld_o), 32'd0);
    check("mid_rst_cnt", 32'(pif.pkt_cnt_o), 32'd0);
    check("mid_rst_busy", 32'(pif.busy_o), 32'd0);
    #1 check("mid_rst_pkt_rdy", 32'(pif.pkt_rdy_o), 32'd1);
    model_cnt = 0;
    exp_q.delete();
    pl_q.delete();
    run_stream(1, 100, 100, 100, 3, xf, sp);
    check("post_rst_flits", 32'(xf), 32'd4);

    // Counter wrap: 255 more tails on top of the one above
    run_stream(255, 100, 100, 100, 0, xf, sp);
    @(negedge clk);
    check("cnt_wrap", 32'(pif.pkt_cnt_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
